// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the 8 KB VRAM between MC6847 display fetch and Z80 CPU.
// Define VRAM_SNOW_EN to let the CPU win collisions (VZ200 "snow").
module vram_arbiter #(
   parameter int AW = 13,
   parameter int DW = 8,
   parameter int SW = 8
) (
   input  logic          PIX_CLK,
   input  logic          RESET,
   input  logic          VID_RD,
   input  logic [AW-1:0] VID_DA,
   output logic [DW-1:0] VID_DD,
   input  logic          CPU_REQ,
   input  logic          CPU_WR,
   input  logic [AW-1:0] CPU_ADDR,
   input  logic [DW-1:0] CPU_DIN,
   output logic [DW-1:0] CPU_DOUT,
   output logic          CPU_ACK,
   output logic          CPU_WAIT,
   output logic [SW-1:0] STALL_CNT,
   output logic          RAM_CE,
   output logic          RAM_WE,
   output logic [AW-1:0] RAM_ADDR,
   output logic [DW-1:0] RAM_WDATA,
   input  logic [DW-1:0] RAM_RDATA
);

   typedef enum logic [1:0] {IDLE, PEND, RDWAIT, DONE} state_t;

   state_t        state_q, state_d;
   logic          ack_q, ack_d;
   logic [SW-1:0] stall_q, stall_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          vid_pend_q;
   logic [DW-1:0] vid_dd_q, vid_dd_d;
   logic          vid_go;
   logic          cpu_go;

`ifdef VRAM_SNOW_EN
   logic          snow_q;
   logic          snow_wr_q;
   logic [DW-1:0] snow_dat_q;

   assign cpu_go = (state_q == PEND);
   assign vid_go = VID_RD & ~cpu_go;
`else
   assign vid_go = VID_RD;
   assign cpu_go = (state_q == PEND) & ~VID_RD;
`endif

   always_comb begin
      RAM_CE   = 1'b0;
      RAM_WE   = 1'b0;
      RAM_ADDR = VID_DA;
      if (!RESET) begin
         if (cpu_go) begin
            RAM_CE   = 1'b1;
            RAM_WE   = CPU_WR;
            RAM_ADDR = CPU_ADDR;
         end else if (vid_go) begin
            RAM_CE   = 1'b1;
         end
      end
   end

   assign RAM_WDATA = CPU_DIN;

   always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      stall_d = stall_q;
      dout_d  = dout_q;
      unique case (state_q)
         IDLE: begin
            if (CPU_REQ) begin
               state_d = PEND;
               stall_d = '0;
            end
         end
         PEND: begin
            if (cpu_go) begin
               state_d = CPU_WR ? DONE : RDWAIT;
               ack_d   = CPU_WR;
            end else if (stall_q != '1) begin
               stall_d = stall_q + SW'(1);
            end
         end
         RDWAIT: begin
            dout_d  = RAM_RDATA;
            ack_d   = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            // held request must drop before a new access is accepted
            if (!CPU_REQ) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      vid_dd_d = vid_dd_q;
      if (vid_pend_q) vid_dd_d = RAM_RDATA;
`ifdef VRAM_SNOW_EN
      if (snow_q) vid_dd_d = snow_wr_q ? snow_dat_q : RAM_RDATA;
`endif
   end

   always_ff @(posedge PIX_CLK) begin
      if (RESET) begin
         state_q    <= IDLE;
         ack_q      <= 1'b0;
         stall_q    <= '0;
         dout_q     <= '0;
         vid_pend_q <= 1'b0;
         vid_dd_q   <= '0;
      end else begin
         state_q    <= state_d;
         ack_q      <= ack_d;
         stall_q    <= stall_d;
         dout_q     <= dout_d;
         vid_pend_q <= vid_go;
         vid_dd_q   <= vid_dd_d;
      end
   end

`ifdef VRAM_SNOW_EN
   always_ff @(posedge PIX_CLK) begin
      if (RESET) begin
         snow_q     <= 1'b0;
         snow_wr_q  <= 1'b0;
         snow_dat_q <= '0;
      end else begin
         snow_q     <= VID_RD & cpu_go;
         snow_wr_q  <= CPU_WR;
         snow_dat_q <= CPU_DIN;
      end
   end
`endif

   assign VID_DD    = vid_dd_q;
   assign CPU_DOUT  = dout_q;
   assign CPU_ACK   = ack_q;
   assign CPU_WAIT  = CPU_REQ & ~ack_q;
   assign STALL_CNT = stall_q;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port 8 KB video RAM between the MC6847 display fetch and the Z80 CPU bus.
- The display fetch has absolute priority, because its timing is fixed by the VGA raster.
- The CPU is served in cycles the display leaves idle. CPU stalls are reported through a wait signal that feeds the Z80 WAIT_N logic.
- Sits between MC6847_VGA (RD/DA/DD) and the VRAM macro.

Parameters:
AW, 13, VRAM address width (8 KB)
DW, 8, data width
SW, 8, width of saturating stall counter

Ports:
PIX_CLK  in  1  pixel clock; the only clock
RESET  in  1  synchronous active-high reset
VID_RD  in  1  display fetch request, one cycle per byte
VID_DA  in  AW  display fetch address
VID_DD  out  DW  display fetch data, registered
CPU_REQ  in  1  CPU access request, level, held until CPU_ACK
CPU_WR  in  1  1 = write, 0 = read; stable while CPU_REQ
CPU_ADDR  in  AW  CPU address; stable while CPU_REQ
CPU_DIN  in  DW  CPU write data
CPU_DOUT  out  DW  CPU read data, registered, valid with CPU_ACK
CPU_ACK  out  1  one-cycle completion pulse
CPU_WAIT  out  1  CPU_REQ & ~CPU_ACK, combinational
STALL_CNT  out  SW  cycles the current/last CPU access lost to display
RAM_CE  out  1  VRAM enable, combinational
RAM_WE  out  1  VRAM write enable, combinational
RAM_ADDR  out  AW  VRAM address, combinational
RAM_WDATA  out  DW  VRAM write data
RAM_RDATA  in  DW  VRAM read data, valid one cycle after a read cycle

Behaviour:
- One clock, PIX_CLK. Synchronous active-high RESET. All state changes occur on the rising edge of PIX_CLK.
- Reset state:
  - FSM = IDLE.
  - VID_DD = 0, CPU_DOUT = 0, CPU_ACK = 0, STALL_CNT = 0.
  - The vid_pend and cpu_rd_pend flags are cleared.
  - RAM_CE = 0 and RAM_WE = 0 while RESET is high, regardless of inputs.
- Port mux, combinational, per cycle:
  - If VID_RD = 1: RAM_CE = 1, RAM_WE = 0, RAM_ADDR = VID_DA.
  - Else if FSM = PEND: RAM_CE = 1, RAM_WE = CPU_WR, RAM_ADDR = CPU_ADDR, RAM_WDATA = CPU_DIN.
  - Else: RAM_CE = 0.
- Display path:
  - A display read in cycle N sets vid_pend.
  - In cycle N+1, RAM_RDATA is registered into VID_DD, which is visible from cycle N+2. Fixed 2-cycle latency.
  - VID_DD holds its value between fetches.
  - Back-to-back VID_RD is fully pipelined.
- CPU FSM states: IDLE, PEND, RDWAIT, DONE.
  - IDLE: CPU_REQ = 1 -> PEND. STALL_CNT is cleared on this transition.
  - PEND, VID_RD = 1: stay in PEND. STALL_CNT increments and saturates at 2^SW-1.
  - PEND, VID_RD = 0, CPU_WR = 1: write issued this cycle -> DONE with CPU_ACK = 1 in the next cycle.
  - PEND, VID_RD = 0, CPU_WR = 0: read issued -> RDWAIT.
  - RDWAIT: CPU_DOUT <= RAM_RDATA, CPU_ACK = 1 in the next cycle, -> DONE.
  - DONE: CPU_ACK lasts exactly one cycle. Stay in DONE until CPU_REQ = 0, then -> IDLE. This blocks double execution of a held request.
- CPU latency with no contention, REQ first seen at edge N:
  - Write: ACK high in cycle N+2.
  - Read: ACK high in cycle N+3.
  - Each cycle with VID_RD = 1 while in PEND adds one cycle.
- Simultaneous VID_RD and a CPU issue attempt: the display always wins (without the optional feature). RDWAIT never conflicts, because RAM is not driven by the CPU in that state.
- CPU_REQ dropped while in PEND (protocol violation): the access still completes. The FSM then passes through DONE to IDLE.
- RESET asserted mid-access: the access is abandoned, no ACK is issued, and the FSM returns to IDLE. A write that had already been issued may have landed.
- Address arithmetic: none. Addresses are passed through unmodified; widths are exactly AW.

Optional Feature:
- Macro: VRAM_SNOW_EN.
- With the macro defined (authentic VZ200 "snow"):
  - In PEND the CPU wins even when VID_RD = 1. STALL_CNT stays 0.
  - The colliding display fetch is not issued. Its VID_DD slot, still at 2-cycle latency, captures the bus word instead:
    - CPU_DIN for a write, registered at the issue cycle.
    - RAM_RDATA of the CPU read.
- Without the macro: display strict priority as described above; a display fetch never returns CPU data.

Test Plan:
- Reset: hold RESET for 3 cycles with all inputs active -> RAM_CE = 0, VID_DD = 0, CPU_ACK = 0, STALL_CNT = 0. After release, FSM is in IDLE.
- Display only: VRAM preloaded [0x0100..0x0103] = 11, 22, 33, 44; VID_RD = 1 for 4 cycles at addresses 0x0100..0x0103 -> VID_DD = 0x11, 0x22, 0x33, 0x44 on consecutive cycles starting 2 cycles after the first request.
- CPU write, then read, idle display:
  - Write 0x5A to 0x1FFF -> ACK 2 cycles after REQ.
  - Read 0x1FFF -> CPU_DOUT = 0x5A with ACK 3 cycles after REQ.
  - CPU_WAIT is high exactly until ACK.
- Contention: CPU read of 0x0200 pending while VID_RD is held for 5 cycles -> RAM never driven by the CPU during those cycles. STALL_CNT = 5, ACK 8 cycles after REQ, display data stream uncorrupted.
- Held request: CPU_REQ kept high for 10 cycles after ACK -> exactly one RAM write, one ACK pulse, FSM remains in DONE until REQ falls.
- VRAM_SNOW_EN: CPU write 0xAA to 0x0010 colliding with VID_RD to 0x0020 -> RAM write occurs, VID_DD = 0xAA two cycles later, STALL_CNT = 0. Without the macro, VID_DD = mem[0x0020] and the write is delayed by one cycle.
